fft_bitrev_reorder: RTL and testbench



---
 rtl/fft_bitrev_reorder.sv | 181 ++++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer turning bit-reversed FFT frames into natural order.
// One bank fills while the other drains; full flags hand banks between the two.

module fft_bitrev_bank #(
  parameter int N  = 128,
  parameter int DW = 32,
  localparam int AW = $clog2(N)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

module fft_bitrev_reorder #(
  parameter int N     = 128,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  input  logic             rev_en,
  input  logic             hold,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             do_last,
  output logic             ovf
);
  localparam int NN = $clog2(N);
  localparam int DW = 2 * WIDTH;
  localparam logic [NN-1:0] LAST = NN'(N - 1);
  localparam logic [NN-1:0] ONE  = NN'(1);

  typedef enum logic {IDLE, READ} rd_state_e;

  function automatic logic [NN-1:0] bitrev(input logic [NN-1:0] a);
    logic [NN-1:0] r;
    for (int i = 0; i < NN; i++) r[i] = a[NN-1-i];
    return r;
  endfunction

  // writer
  logic          wbank_q, wbank_d;
  logic [NN-1:0] wcnt_q, wcnt_d;
  logic          wrev_q, wrev_d;
  logic          wr_acc, wr_end, wr_rev;
  logic [NN-1:0] waddr;

  // shared flags
  logic [1:0]    full_q, full_d;
  logic          ovf_q, ovf_d;

  // reader
  rd_state_e     state_q, state_d;
  logic          rbank_q, rbank_d;
  logic [NN-1:0] rcnt_q, rcnt_d;
  logic          rd_go, rd_end;

  // [0] = address issued last edge, [1] = output valid
  logic [1:0]    vld_pipe_q, vld_pipe_d;
  logic [1:0]    last_pipe_q, last_pipe_d;
  logic          rsel_q, rsel_d;
  logic [WIDTH-1:0] do_re_q, do_re_d, do_im_q, do_im_d;

  logic [1:0]        bank_we, bank_re;
  logic [1:0][DW-1:0] bank_rd;
  logic [DW-1:0]     rd_word;

  always_comb begin
    wr_acc  = di_en & ~full_q[wbank_q];
    wr_rev  = (wcnt_q == '0) ? rev_en : wrev_q;
    waddr   = wr_rev ? bitrev(wcnt_q) : wcnt_q;
    wr_end  = wr_acc && (wcnt_q == LAST);
    wbank_d = wbank_q;
    wcnt_d  = wcnt_q;
    wrev_d  = wrev_q;
    if (wr_acc) begin
      wrev_d = wr_rev;
      wcnt_d = wcnt_q + ONE;
      if (wr_end) wbank_d = ~wbank_q;
    end
    ovf_d = ovf_q | (di_en & full_q[wbank_q]);
  end

  // READ implies full[rbank]; the IDLE term lets a freshly filled bank issue immediately
  always_comb begin
    rd_go   = ~hold & ((state_q == READ) | full_q[rbank_q]);
    rd_end  = rd_go && (rcnt_q == LAST);
    rcnt_d  = rd_go ? rcnt_q + ONE : rcnt_q;
    rbank_d = rd_end ? ~rbank_q : rbank_q;
    state_d = state_q;
    if (rd_end)
      state_d = full_q[~rbank_q] ? READ : IDLE;
    else if (state_q == IDLE && full_q[rbank_q])
      state_d = READ;
  end

  // reader clear and writer set never hit the same bank on one edge
  always_comb begin
    full_d = full_q;
    if (rd_end) full_d[rbank_q] = 1'b0;
    if (wr_end) full_d[wbank_q] = 1'b1;
  end

  always_comb begin
    bank_we     = wr_acc ? (2'b01 << wbank_q) : 2'b00;
    bank_re     = rd_go  ? (2'b01 << rbank_q) : 2'b00;
    rd_word     = bank_rd[rsel_q];
    vld_pipe_d  = {vld_pipe_q[0], rd_go};
    last_pipe_d = {last_pipe_q[0], rd_end};
    rsel_d      = rd_go ? rbank_q : rsel_q;
    do_re_d     = vld_pipe_q[0] ? rd_word[DW-1:WIDTH] : '0;
    do_im_d     = vld_pipe_q[0] ? rd_word[WIDTH-1:0]  : '0;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_bitrev_bank #(.N(N), .DW(DW)) u_bank (
      .clock (clock),
      .we    (bank_we[b]),
      .waddr (waddr),
      .wdata ({di_re, di_im}),
      .re    (bank_re[b]),
      .raddr (rcnt_q),
      .rdata (bank_rd[b])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wbank_q     <= 1'b0;
      wcnt_q      <= '0;
      wrev_q      <= 1'b0;
      full_q      <= '0;
      ovf_q       <= 1'b0;
      state_q     <= IDLE;
      rbank_q     <= 1'b0;
      rcnt_q      <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      rsel_q      <= 1'b0;
      do_re_q     <= '0;
      do_im_q     <= '0;
    end else begin
      wbank_q     <= wbank_d;
      wcnt_q      <= wcnt_d;
      wrev_q      <= wrev_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      rbank_q     <= rbank_d;
      rcnt_q      <= rcnt_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      rsel_q      <= rsel_d;
      do_re_q     <= do_re_d;
      do_im_q     <= do_im_d;
    end
  end

  assign do_en   = vld_pipe_q[1];
  assign do_last = last_pipe_q[1];
  assign do_re   = do_re_q;
  assign do_im   = do_im_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomised bench for the reorder buffer: a frame-level model (bit-reversed
// index lookup on captured frames) feeds per-instance expected-output queues.

module tb_fft_bitrev_reorder;
  localparam int W = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic         di_en, rev_en, hold, do_en, do_last, ovf;
  logic [W-1:0] di_re, di_im, do_re, do_im;
  logic         di_en8, rev_en8, hold8, do_en8, do_last8, ovf8;
  logic [W-1:0] di_re8, di_im8, do_re8, do_im8;

  fft_bitrev_reorder #(.N(128), .WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .rev_en(rev_en), .hold(hold), .do_en(do_en), .do_re(do_re), .do_im(do_im),
    .do_last(do_last), .ovf(ovf)
  );

  fft_bitrev_reorder #(.N(8), .WIDTH(W)) dut8 (
    .clock(clock), .reset_n(reset_n), .di_en(di_en8), .di_re(di_re8), .di_im(di_im8),
    .rev_en(rev_en8), .hold(hold8), .do_en(do_en8), .do_re(do_re8), .do_im(do_im8),
    .do_last(do_last8), .ovf(ovf8)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int brev(input int v, input int nb);
    int r = 0;
    for (int i = 0; i < nb; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  logic [2*W:0] q[$];
  logic [2*W:0] q8[$];
  int run = 0, max_run = 0, run8 = 0, max_run8 = 0;

  always @(negedge clock) begin
    logic [2*W:0] e;
    if (!reset_n) run = 0;
    else if (do_en) begin
      run++;
      if (q.size() == 0) chk("unexpected_out", do_en, 1'b0);
      else begin
        e = q.pop_front();
        chk("out_data", {do_last, do_re, do_im}, e);
      end
    end else begin
      if (run > max_run) max_run = run;
      run = 0;
      chk("idle_zero", {do_last, do_re, do_im}, 0);
    end
  end

  always @(negedge clock) begin
    logic [2*W:0] e;
    if (!reset_n) run8 = 0;
    else if (do_en8) begin
      run8++;
      if (q8.size() == 0) chk("unexpected_out8", do_en8, 1'b0);
      else begin
        e = q8.pop_front();
        chk("out_data8", {do_last8, do_re8, do_im8}, e);
      end
    end else begin
      if (run8 > max_run8) max_run8 = run8;
      run8 = 0;
      chk("idle_zero8", {do_last8, do_re8, do_im8}, 0);
    end
  end

  task automatic send_frame(input bit rev, input bit gaps, input bit rnd, input int nsamp,
                            output int last_edge);
    logic [W-1:0] re_a[128];
    logic [W-1:0] im_a[128];
    int idx;
    last_edge = 0;
    for (int k = 0; k < nsamp; k++) begin
      if (gaps && k > 0) begin
        @(negedge clock);
        di_en = 1'b0; di_re = W'($urandom); di_im = W'($urandom); rev_en = 1'($urandom);
      end
      @(negedge clock);
      re_a[k] = rnd ? W'($urandom) : W'(k);
      im_a[k] = rnd ? W'($urandom) : W'(-k);
      di_en = 1'b1; di_re = re_a[k]; di_im = im_a[k];
      rev_en = (k == 0) ? rev : 1'($urandom);
      last_edge = edge_cnt + 1;
    end
    if (nsamp == 128)
      for (int n = 0; n < 128; n++) begin
        idx = rev ? brev(n, 7) : n;
        q.push_back({(n == 127), re_a[idx], im_a[idx]});
      end
  endtask

  task automatic send8(input int base, input bit push);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      di_en8 = 1'b1; di_re8 = W'(base + k); di_im8 = W'(-(base + k)); rev_en8 = 1'b1;
    end
    if (push)
      for (int n = 0; n < 8; n++)
        q8.push_back({(n == 7), W'(base + brev(n, 3)), W'(-(base + brev(n, 3)))});
  endtask

  task automatic wait_out(input int e_last, input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      di_en = 1'b0;
      if (do_en) break;
    end
    chk(tag, edge_cnt - e_last, 2);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      di_en = 1'b0; di_en8 = 1'b0;
      if (q.size() == 0 && q8.size() == 0) break;
    end
    repeat (3) @(negedge clock);
    chk("drain", q.size(), 0);
    chk("drain8", q8.size(), 0);
  endtask

  initial begin
    int le, e0, cnt, last;
    bit pulsed;
    di_en = 0; di_re = 0; di_im = 0; rev_en = 0; hold = 0;
    di_en8 = 0; di_re8 = 0; di_im8 = 0; rev_en8 = 0; hold8 = 0;
    #3 reset_n = 1'b0;
    #1;
    chk("rst_do_en", do_en, 0);
    chk("rst_do_data", {do_last, do_re, do_im}, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // 1: ramp frame, bit-reversed
    max_run = 0;
    send_frame(1'b1, 1'b0, 1'b0, 128, le);
    wait_out(le, "t1_latency");
    drain(400);
    chk("t1_run", max_run, 128);
    chk("t1_ovf", ovf, 0);

    // 2: natural frame then reversed frame; rev_en toggles mid-frame
    send_frame(1'b0, 1'b0, 1'b0, 128, le);
    send_frame(1'b1, 1'b0, 1'b1, 128, le);
    drain(600);
    chk("t2_ovf", ovf, 0);

    // 3: three back-to-back random frames
    max_run = 0;
    for (int f = 0; f < 3; f++) send_frame(1'b1, 1'b0, 1'b1, 128, le);
    drain(600);
    chk("t3_run", max_run, 384);
    chk("t3_ovf", ovf, 0);

    // 4: di_en alternating
    max_run = 0;
    send_frame(1'b1, 1'b1, 1'b0, 128, le);
    wait_out(le, "t4_latency");
    drain(400);
    chk("t4_run", max_run, 128);

    // 5: N=8 with hold, overflow, single hold pulse
    hold8 = 1'b1;
    send8(10, 1'b1);
    send8(20, 1'b1);
    @(negedge clock); di_en8 = 1'b0;
    chk("t5_ovf_pre", ovf8, 0);
    chk("t5_hold_blocks", do_en8, 0);
    send8(30, 1'b0);
    @(negedge clock); di_en8 = 1'b0;
    chk("t5_ovf_set", ovf8, 1);
    chk("t5_queued", q8.size(), 16);
    repeat (4) @(negedge clock);
    chk("t5_hold_blocks2", do_en8, 0);
    max_run8 = 0;
    hold8 = 1'b0;
    drain(100);
    chk("t5_run", max_run8, 16);
    chk("t5_ovf_sticky", ovf8, 1);
    send8(40, 1'b1);
    e0 = -1; cnt = 0; last = 0; pulsed = 0;
    for (int i = 0; i < 60 && cnt < 8; i++) begin
      @(negedge clock);
      di_en8 = 1'b0; hold8 = 1'b0;
      if (do_en8) begin
        if (e0 < 0) e0 = edge_cnt;
        cnt++;
        last = edge_cnt;
        if (cnt == 3 && !pulsed) begin hold8 = 1'b1; pulsed = 1; end
      end
    end
    hold8 = 1'b0;
    chk("t5_pulse_cnt", cnt, 8);
    chk("t5_pulse_span", last - e0 + 1, 9);
    drain(100);
    chk("t5_ovf_still", ovf8, 1);

    // 6: async reset while draining one frame and filling another
    send_frame(1'b1, 1'b0, 1'b1, 128, le);
    send_frame(1'b1, 1'b0, 1'b1, 50, le);
    chk("t6_busy", do_en, 1);
    #2 reset_n = 1'b0;
    di_en = 1'b0;
    #1;
    chk("t6_rst_do_en", do_en, 0);
    chk("t6_rst_data", {do_last, do_re, do_im}, 0);
    chk("t6_rst_ovf8", ovf8, 0);
    q.delete(); q8.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    max_run = 0;
    send_frame(1'b1, 1'b0, 1'b1, 128, le);
    wait_out(le, "t6_latency");
    drain(400);
    chk("t6_run", max_run, 128);
    chk("t6_ovf", ovf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
